// File: rtl/kl_arbiter.sv
// Two-to-one KL bus arbiter: round-robin registered grant on the request channel,
// locked for whole write bursts; responses demuxed combinationally by dstid.
module kl_arbiter #(
    parameter  int unsigned PORT_BIT = 4,
    localparam int unsigned AW       = 32,
    localparam int unsigned DW       = 64,
    localparam int unsigned MW       = 8,
    localparam int unsigned SW       = 3,
    localparam int unsigned IW       = 5,
    localparam int unsigned BW       = 3
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [AW-1:0] m0_req_addr,
    input  logic          m0_req_wen,
    input  logic [DW-1:0] m0_req_wdata,
    input  logic [MW-1:0] m0_req_wmask,
    input  logic [SW-1:0] m0_req_size,
    input  logic [IW-1:0] m0_req_srcid,
    input  logic          m0_req_valid,
    output logic          m0_req_ready,
    output logic [DW-1:0] m0_resp_rdata,
    output logic [SW-1:0] m0_resp_size,
    output logic [IW-1:0] m0_resp_dstid,
    output logic          m0_resp_valid,
    input  logic          m0_resp_ready,

    input  logic [AW-1:0] m1_req_addr,
    input  logic          m1_req_wen,
    input  logic [DW-1:0] m1_req_wdata,
    input  logic [MW-1:0] m1_req_wmask,
    input  logic [SW-1:0] m1_req_size,
    input  logic [IW-1:0] m1_req_srcid,
    input  logic          m1_req_valid,
    output logic          m1_req_ready,
    output logic [DW-1:0] m1_resp_rdata,
    output logic [SW-1:0] m1_resp_size,
    output logic [IW-1:0] m1_resp_dstid,
    output logic          m1_resp_valid,
    input  logic          m1_resp_ready,

    output logic [AW-1:0] s_req_addr,
    output logic          s_req_wen,
    output logic [DW-1:0] s_req_wdata,
    output logic [MW-1:0] s_req_wmask,
    output logic [SW-1:0] s_req_size,
    output logic [IW-1:0] s_req_srcid,
    output logic          s_req_valid,
    input  logic          s_req_ready,

    input  logic [DW-1:0] s_resp_rdata,
    input  logic [SW-1:0] s_resp_size,
    input  logic [IW-1:0] s_resp_dstid,
    input  logic          s_resp_valid,
    output logic          s_resp_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_gnt, w_gnt_nxt;
    logic          r_rr, w_rr_nxt;
    logic [BW-1:0] r_beats_left, w_beats_nxt;

    logic          w_win;
    logic [AW-1:0] w_sel_addr;
    logic          w_sel_wen;
    logic [DW-1:0] w_sel_wdata;
    logic [MW-1:0] w_sel_wmask;
    logic [SW-1:0] w_sel_size;
    logic [IW-1:0] w_sel_srcid;
    logic          w_sel_valid;
    logic          w_resp_port;

    // Remaining beats after the first: only writes wider than 8 bytes are bursts.
    function automatic logic [BW-1:0] f_burst_last(input logic wen, input logic [SW-1:0] size);
        logic [BW-1:0] v;
        v = '0;
        if (wen && size > SW'(3)) begin
            case (size)
                SW'(4):  v = BW'(1);
                SW'(5):  v = BW'(3);
                default: v = BW'(7);
            endcase
        end
        return v;
    endfunction

    assign w_win       = r_rr ? m1_req_valid : ~m0_req_valid;

    assign w_sel_addr  = r_gnt ? m1_req_addr  : m0_req_addr;
    assign w_sel_wen   = r_gnt ? m1_req_wen   : m0_req_wen;
    assign w_sel_wdata = r_gnt ? m1_req_wdata : m0_req_wdata;
    assign w_sel_wmask = r_gnt ? m1_req_wmask : m0_req_wmask;
    assign w_sel_size  = r_gnt ? m1_req_size  : m0_req_size;
    assign w_sel_srcid = r_gnt ? m1_req_srcid : m0_req_srcid;
    assign w_sel_valid = r_gnt ? m1_req_valid : m0_req_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_gnt        <= 1'b0;
            r_rr         <= 1'b0;
            r_beats_left <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_gnt        <= w_gnt_nxt;
            r_rr         <= w_rr_nxt;
            r_beats_left <= w_beats_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_rr_nxt     = r_rr;
        w_beats_nxt  = r_beats_left;
        s_req_addr   = '0;
        s_req_wen    = 1'b0;
        s_req_wdata  = '0;
        s_req_wmask  = '0;
        s_req_size   = '0;
        s_req_srcid  = '0;
        s_req_valid  = 1'b0;
        m0_req_ready = 1'b0;
        m1_req_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (m0_req_valid || m1_req_valid) begin
                    w_gnt_nxt   = w_win;
                    w_beats_nxt = w_win ? f_burst_last(m1_req_wen, m1_req_size)
                                        : f_burst_last(m0_req_wen, m0_req_size);
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                s_req_addr            = w_sel_addr;
                s_req_wen             = w_sel_wen;
                s_req_wdata           = w_sel_wdata;
                s_req_wmask           = w_sel_wmask;
                s_req_size            = w_sel_size;
                s_req_srcid           = w_sel_srcid;
                s_req_srcid[PORT_BIT] = r_gnt;
                s_req_valid           = w_sel_valid;
                if (r_gnt) m1_req_ready = s_req_ready;
                else       m0_req_ready = s_req_ready;
                // Grant stays locked until the last beat hands off, even across valid gaps.
                if (w_sel_valid && s_req_ready) begin
                    if (r_beats_left == '0) begin
                        w_state_nxt = IDLE;
                        w_rr_nxt    = ~r_gnt;
                    end else begin
                        w_beats_nxt = r_beats_left - BW'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Response path: pure demux on the port bit of dstid, independent of request state.
    assign w_resp_port   = s_resp_dstid[PORT_BIT];
    assign m0_resp_valid = s_resp_valid && !w_resp_port;
    assign m1_resp_valid = s_resp_valid &&  w_resp_port;
    assign m0_resp_rdata = s_resp_rdata;
    assign m1_resp_rdata = s_resp_rdata;
    assign m0_resp_size  = s_resp_size;
    assign m1_resp_size  = s_resp_size;
    assign m0_resp_dstid = s_resp_dstid;
    assign m1_resp_dstid = s_resp_dstid;
    assign s_resp_ready  = w_resp_port ? m1_resp_ready : m0_resp_ready;

endmodule

// File: tb/tb_kl_arbiter.sv
// Bench for kl_arbiter: per-port requester models feed a scoreboard of expected
// downstream beats; grant order and response demux are checked against bench constants.
module tb_kl_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [2:0]  size;
        logic [4:0]  srcid;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_req_addr, m1_req_addr, s_req_addr;
    logic        m0_req_wen, m1_req_wen, s_req_wen;
    logic [63:0] m0_req_wdata, m1_req_wdata, s_req_wdata;
    logic [7:0]  m0_req_wmask, m1_req_wmask, s_req_wmask;
    logic [2:0]  m0_req_size, m1_req_size, s_req_size;
    logic [4:0]  m0_req_srcid, m1_req_srcid, s_req_srcid;
    logic        m0_req_valid, m1_req_valid, s_req_valid;
    logic        m0_req_ready, m1_req_ready, s_req_ready;
    logic [63:0] m0_resp_rdata, m1_resp_rdata, s_resp_rdata;
    logic [2:0]  m0_resp_size, m1_resp_size, s_resp_size;
    logic [4:0]  m0_resp_dstid, m1_resp_dstid, s_resp_dstid;
    logic        m0_resp_valid, m1_resp_valid, s_resp_valid;
    logic        m0_resp_ready, m1_resp_ready, s_resp_ready;

    beat_t drv[2];
    logic  vld[2];
    logic  mrdy[2];
    logic  acc[2];
    logic  ld[2];
    logic  pu[2];
    int    gc[2];
    beat_t bq[2][$];
    int    gq[2][$];
    beat_t eq[2][$];
    logic  got_q[$];
    logic  exp_ord[$];
    int    cyc_q[$];
    int    cyc;
    int    rdy_mode;
    int    n_chk;
    int    n_bad;

    always #5 clk = ~clk;

    assign m0_req_addr  = drv[0].addr;
    assign m0_req_wen   = drv[0].wen;
    assign m0_req_wdata = drv[0].wdata;
    assign m0_req_wmask = drv[0].wmask;
    assign m0_req_size  = drv[0].size;
    assign m0_req_srcid = drv[0].srcid;
    assign m0_req_valid = vld[0];
    assign m1_req_addr  = drv[1].addr;
    assign m1_req_wen   = drv[1].wen;
    assign m1_req_wdata = drv[1].wdata;
    assign m1_req_wmask = drv[1].wmask;
    assign m1_req_size  = drv[1].size;
    assign m1_req_srcid = drv[1].srcid;
    assign m1_req_valid = vld[1];
    assign mrdy[0]      = m0_req_ready;
    assign mrdy[1]      = m1_req_ready;

    kl_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req_addr(m0_req_addr), .m0_req_wen(m0_req_wen), .m0_req_wdata(m0_req_wdata),
        .m0_req_wmask(m0_req_wmask), .m0_req_size(m0_req_size), .m0_req_srcid(m0_req_srcid),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
        .m0_resp_rdata(m0_resp_rdata), .m0_resp_size(m0_resp_size), .m0_resp_dstid(m0_resp_dstid),
        .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready),
        .m1_req_addr(m1_req_addr), .m1_req_wen(m1_req_wen), .m1_req_wdata(m1_req_wdata),
        .m1_req_wmask(m1_req_wmask), .m1_req_size(m1_req_size), .m1_req_srcid(m1_req_srcid),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
        .m1_resp_rdata(m1_resp_rdata), .m1_resp_size(m1_resp_size), .m1_resp_dstid(m1_resp_dstid),
        .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready),
        .s_req_addr(s_req_addr), .s_req_wen(s_req_wen), .s_req_wdata(s_req_wdata),
        .s_req_wmask(s_req_wmask), .s_req_size(s_req_size), .s_req_srcid(s_req_srcid),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_resp_rdata(s_resp_rdata), .s_resp_size(s_resp_size), .s_resp_dstid(s_resp_dstid),
        .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Queue one transaction (all its beats) on port p; gap_len idle cycles precede beat gap_at.
    task automatic add_txn(input logic p, input logic [31:0] addr, input logic wen,
                           input logic [2:0] size, input logic [4:0] srcid,
                           input int gap0, input int gap_at, input int gap_len);
        beat_t t;
        int    n;
        n = (wen && size > 3'd3) ? (1 << (size - 3'd3)) : 1;
        for (int b = 0; b < n; b++) begin
            t.addr  = addr;
            t.wen   = wen;
            t.wdata = {$urandom, $urandom};
            t.wmask = 8'($urandom);
            t.size  = size;
            t.srcid = srcid;
            bq[p].push_back(t);
            gq[p].push_back(b == 0 ? gap0 : (b == gap_at ? gap_len : 0));
        end
    endtask

    task automatic drive_port(input logic p);
        beat_t e;
        if (acc[p]) begin
            void'(bq[p].pop_front());
            void'(gq[p].pop_front());
            acc[p] = 1'b0;
            ld[p]  = 1'b0;
        end
        vld[p] = 1'b0;
        if (bq[p].size() > 0) begin
            if (!ld[p]) begin
                gc[p] = gq[p][0];
                ld[p] = 1'b1;
                pu[p] = 1'b0;
            end
            if (gc[p] > 0) begin
                gc[p]--;
            end else begin
                vld[p] = 1'b1;
                drv[p] = bq[p][0];
                if (!pu[p]) begin
                    e          = bq[p][0];
                    e.srcid[4] = p;
                    eq[p].push_back(e);
                    pu[p]      = 1'b1;
                end
            end
        end
    endtask

    task automatic drive();
        cyc++;
        s_req_ready = (rdy_mode == 0) ? 1'b1 : cyc[0];
        drive_port(1'b0);
        drive_port(1'b1);
    endtask

    task automatic sample();
        logic [1:0] hs;
        logic       p;
        beat_t      e;
        beat_t      g;
        hs     = 2'b00;
        acc[0] = vld[0] && mrdy[0];
        acc[1] = vld[1] && mrdy[1];
        if (s_req_valid && s_req_ready) begin
            p     = s_req_srcid[4];
            hs[p] = 1'b1;
            got_q.push_back(p);
            cyc_q.push_back(cyc);
            chk("rdy_steer", 128'({m1_req_ready, m0_req_ready}), 128'(p ? 2'b10 : 2'b01));
            g = {s_req_addr, s_req_wen, s_req_wdata, s_req_wmask, s_req_size, s_req_srcid};
            if (eq[p].size() == 0) begin
                chk("unexpected_beat", 128'(g), 128'(0));
            end else begin
                e = eq[p].pop_front();
                chk("beat", 128'(g), 128'(e));
            end
        end
        if ({acc[1], acc[0]} != 2'b00 || hs != 2'b00)
            chk("acc_vs_hs", 128'({acc[1], acc[0]}), 128'(hs));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        sample();
    endtask

    task automatic clear_bench();
        for (int i = 0; i < 2; i++) begin
            bq[i].delete();
            gq[i].delete();
            eq[i].delete();
            acc[i] = 1'b0;
            ld[i]  = 1'b0;
            pu[i]  = 1'b0;
            gc[i]  = 0;
            vld[i] = 1'b0;
        end
        got_q.delete();
        cyc_q.delete();
        exp_ord.delete();
    endtask

    task automatic run(input int budget);
        int k;
        k = 0;
        while ((bq[0].size() + bq[1].size()) > 0 && k < budget) begin
            step();
            k++;
        end
        if (k >= budget) chk("timeout", 128'(0), 128'(1));
        step();
        chk("leftover0", 128'(eq[0].size()), 128'(0));
        chk("leftover1", 128'(eq[1].size()), 128'(0));
    endtask

    task automatic check_order();
        chk("order_len", 128'(got_q.size()), 128'(exp_ord.size()));
        for (int i = 0; i < got_q.size() && i < exp_ord.size(); i++)
            chk("order", 128'(got_q[i]), 128'(exp_ord[i]));
    endtask

    // Drive one response beat and check the demux against dstid[4].
    task automatic resp_chk(input logic [4:0] dst, input logic r0, input logic r1);
        logic [63:0] rd;
        rd            = {$urandom, $urandom};
        s_resp_valid  = 1'b1;
        s_resp_dstid  = dst;
        s_resp_rdata  = rd;
        s_resp_size   = 3'd3;
        m0_resp_ready = r0;
        m1_resp_ready = r1;
        #1;
        chk("resp_v0", 128'(m0_resp_valid), 128'(!dst[4]));
        chk("resp_v1", 128'(m1_resp_valid), 128'(dst[4]));
        chk("resp_data", 128'({m0_resp_rdata, m1_resp_rdata}), 128'({rd, rd}));
        chk("resp_id", 128'({m0_resp_dstid, m1_resp_dstid, m0_resp_size, m1_resp_size}),
            128'({dst, dst, 3'd3, 3'd3}));
        chk("resp_rdy", 128'(s_resp_ready), 128'(dst[4] ? r1 : r0));
        s_resp_valid = 1'b0;
        #1;
        chk("resp_idle", 128'({m0_resp_valid, m1_resp_valid}), 128'(0));
    endtask

    task automatic do_reset();
        clear_bench();
        rdy_mode = 0;
        rst      = 1'b1;
        step();
        step();
        chk("rst_sreq_valid", 128'(s_req_valid), 128'(0));
        chk("rst_mreq_ready", 128'({m1_req_ready, m0_req_ready}), 128'(0));
        resp_chk(5'h11, 1'b0, 1'b1);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_bad = 0; cyc = 0; rdy_mode = 0;
        rst = 1'b1; s_req_ready = 1'b0;
        s_resp_valid = 1'b0; s_resp_rdata = '0; s_resp_size = '0; s_resp_dstid = '0;
        m0_resp_ready = 1'b0; m1_resp_ready = 1'b0;
        drv[0] = '0; drv[1] = '0;
        clear_bench();

        // Single read on m0: one-cycle arbitration latency, srcid untouched.
        do_reset();
        add_txn(1'b0, 32'h8000_0000, 1'b0, 3'd3, 5'h02, 0, 0, 0);
        step();
        chk("t1_idle_valid", 128'(s_req_valid), 128'(0));
        chk("t1_idle_ready", 128'(m0_req_ready), 128'(0));
        step();
        chk("t1_fwd_valid", 128'(s_req_valid), 128'(1));
        chk("t1_fwd_srcid", 128'(s_req_srcid), 128'(5'h02));
        chk("t1_fwd_addr", 128'(s_req_addr), 128'(32'h8000_0000));
        run(10);
        resp_chk(5'h02, 1'b1, 1'b0);
        resp_chk(5'h02, 1'b0, 1'b1);

        // Simultaneous single reads: m0 first, m1 two cycles later with port bit set.
        do_reset();
        add_txn(1'b0, 32'h1000, 1'b0, 3'd2, 5'h01, 0, 0, 0);
        add_txn(1'b1, 32'h2000, 1'b0, 3'd3, 5'h03, 0, 0, 0);
        run(20);
        exp_ord = '{1'b0, 1'b1};
        check_order();
        if (cyc_q.size() == 2) chk("t2_gap", 128'(cyc_q[1] - cyc_q[0]), 128'(2));
        else chk("t2_nbeats", 128'(cyc_q.size()), 128'(2));
        resp_chk(5'h13, 1'b1, 1'b0);
        resp_chk(5'h13, 1'b0, 1'b1);

        // 8-beat m1 write under toggling ready; m0 read waits for IDLE.
        do_reset();
        rdy_mode = 1;
        add_txn(1'b1, 32'h3000, 1'b1, 3'd6, 5'h07, 0, 0, 0);
        add_txn(1'b0, 32'h4000, 1'b0, 3'd3, 5'h04, 1, 0, 0);
        run(60);
        exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        check_order();

        // m0 4-beat write with a 3-cycle valid gap before beat 3; m1 must stay held off.
        do_reset();
        add_txn(1'b0, 32'h5000, 1'b1, 3'd5, 5'h05, 0, 2, 3);
        add_txn(1'b1, 32'h6000, 1'b0, 3'd1, 5'h06, 1, 0, 0);
        run(40);
        exp_ord = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        check_order();

        // Ten back-to-back single reads per port: strict alternation, nothing lost.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            add_txn(1'b0, 32'h100 * i, 1'b0, 3'(i % 4), 5'(i), 0, 0, 0);
            add_txn(1'b1, 32'h7000 + i, 1'b0, 3'd3, 5'(i + 8), 0, 0, 0);
        end
        run(80);
        for (int i = 0; i < 20; i++) exp_ord.push_back(1'(i % 2));
        check_order();

        // Reset on beat 3 of an m1 burst taken after an m0 read (so rr was 1).
        do_reset();
        add_txn(1'b0, 32'h8000, 1'b0, 3'd3, 5'h08, 0, 0, 0);
        add_txn(1'b1, 32'h9000, 1'b1, 3'd6, 5'h09, 3, 0, 0);
        for (int k = 0; k < 40 && got_q.size() < 4; k++) step();
        chk("t6_pre_beats", 128'(got_q.size()), 128'(4));
        rst = 1'b1;
        clear_bench();
        add_txn(1'b0, 32'hA000, 1'b0, 3'd3, 5'h0A, 0, 0, 0);
        add_txn(1'b1, 32'hB000, 1'b0, 3'd3, 5'h0B, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
        @(negedge clk);
        chk("t6_post_rst_valid", 128'(s_req_valid), 128'(0));
        chk("t6_post_rst_ready", 128'({m1_req_ready, m0_req_ready}), 128'(0));
        sample();
        run(20);
        exp_ord = '{1'b0, 1'b1};
        check_order();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/kl_arbiter.md
# kl_arbiter

Two-to-one arbiter for the KL bus, placed between two KL requesters (instruction-side and data-side cache/uncached ports) and the single downstream KL target (the KL-to-ML external bus bridge). It grants the shared request channel round-robin, keeps the grant locked for every beat of a multi-beat write, tags each request with its port index in `srcid[4]`, and steers responses back by `dstid[4]`. The request path is registered-grant; the response path is a combinational demux.

## Interface
- `PORT_BIT`, 4, srcid/dstid bit overwritten with and decoded as port index (0 or 1).
- `clk  input  1`  sole clock.
- `rst  input  1`  synchronous, active-high reset.
- `m0_req_addr`, `m1_req_addr`  `input  32`  request address.
- `m0_req_wen`, `m1_req_wen`  `input  1`  write enable.
- `m0_req_wdata`, `m1_req_wdata`  `input  64`  write data beat.
- `m0_req_wmask`, `m1_req_wmask`  `input  8`  byte mask.
- `m0_req_size`, `m1_req_size`  `input  3`  log2 transfer bytes (0..6).
- `m0_req_srcid`, `m1_req_srcid`  `input  5`  requester tag.
- `m0_req_valid`, `m1_req_valid`  `input  1`  request beat valid.
- `m0_req_ready`, `m1_req_ready`  `output  1`  request beat accepted.
- `m0_resp_rdata`, `m1_resp_rdata`  `output  64`; `m*_resp_size`  `output  3`; `m*_resp_dstid`  `output  5`.
- `m0_resp_valid`, `m1_resp_valid`  `output  1`; `m0_resp_ready`, `m1_resp_ready`  `input  1`.
- `s_req_addr  output  32`, `s_req_wen  output  1`, `s_req_wdata  output  64`, `s_req_wmask  output  8`, `s_req_size  output  3`, `s_req_srcid  output  5`, `s_req_valid  output  1`, `s_req_ready  input  1`.
- `s_resp_rdata  input  64`, `s_resp_size  input  3`, `s_resp_dstid  input  5`, `s_resp_valid  input  1`, `s_resp_ready  output  1`.

## Operation
- Beat count of a request: `wen && size>3` -> 2^(size-3) beats (size 4/5/6 -> 2/4/8); all reads and writes with size<=3 -> 1 beat. size 7 is illegal; treated as 8 beats.
- State: `IDLE`, `XFER`. Registers: `gnt` (1 bit), `rr` (1 bit, port favoured next), `beats_left` (3 bits).
- IDLE: no request forwarded, both `m*_req_ready`=0. If any `m*_req_valid`: winner = `rr` if that port is valid, else the other; `gnt`<=winner, `beats_left`<=beat count of winner's current beat minus 1, go XFER.
- XFER: `s_req_*` = port `gnt` fields, except `s_req_srcid[PORT_BIT]`=`gnt`; `s_req_valid`=`m{gnt}_req_valid`; `m{gnt}_req_ready`=`s_req_ready`; other port's ready=0.
- Handshake beat = `s_req_valid && s_req_ready`. On a beat with `beats_left`==0: go IDLE, `rr`<=~`gnt`. Otherwise `beats_left` decrements. Grant is never revoked mid-burst, including when the granted requester drops valid between beats.
- Response: `m{i}_resp_valid` = `s_resp_valid && s_resp_dstid[PORT_BIT]==i`; rdata/size/dstid broadcast unchanged to both ports; `s_resp_ready` = `m{dstid[PORT_BIT]}_resp_ready`. Independent of request state.

## Timing
- Reset: state IDLE, `gnt`=0, `rr`=0, `beats_left`=0; `s_req_valid`=0, `m*_req_ready`=0. Response outputs are combinational and follow inputs even during reset.
- Arbitration latency: valid seen in IDLE at cycle N -> forwarded on `s_req_*` at cycle N+1; earliest acceptance N+1.
- One mandatory IDLE cycle between consecutive transactions; single-beat throughput is 1 per 2 cycles.
- Requesters hold valid and fields stable until ready; arbiter adds no buffering, so `s_req_ready` stalls propagate the same cycle.
- Simultaneous valids in IDLE: `rr` decides; after port i completes, the other port wins next contention (strict alternation).
- Reset asserted mid-burst: next cycle IDLE, remaining beats discarded; requesters are reset together.
- Response channel may be active in the same cycle as a request beat; no interaction.

## Test plan
- Reset then single read on m0 (addr 0x8000_0000, size 3, srcid 0x02) -> `s_req_valid` 1 cycle after m0 valid, `s_req_srcid`=0x02; response dstid 0x02 appears only on m0.
- m0 and m1 valid in same cycle after reset (single-beat reads) -> m0 granted first, m1 forwarded 2 cycles later with `s_req_srcid[4]`=1; response dstid 0x13 -> only `m1_resp_valid`.
- m1 write size 6 (8 beats), m0 read pending, `s_req_ready` toggling every other cycle -> all 8 m1 beats forwarded contiguously in grant, m0 held off until IDLE, then m0 granted.
- m0 burst size 5 with m0 valid dropped 3 cycles between beats 2 and 3 -> grant held, m1 request stays ungranted, 4 beats total delivered.
- Back-to-back contention for 10 transactions each -> grants strictly alternate 0,1,0,1...; no lost or duplicated beats.
- `rst` asserted on beat 3 of a size-6 write -> `s_req_valid`=0 next cycle, state IDLE, `rr`=0; fresh m1 request granted normally.
